// File: rtl/seq_match_display.sv
// Display stage for the 010110 sequence detector: 3-digit BCD match counter and a
// four-digit multiplexed 7-segment driver. Define SEQ_DISP_LZB_EN for leading-zero blanking.
module seq_match_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_valid,
  input  logic       z,
  input  logic [2:0] state,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] anode,
  output logic       ovf
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned SEL_W   = 2;
  localparam logic [SEG_W-1:0]   SEG_BLANK = 7'b1111111;
  localparam logic [AN_W-1:0]    AN_OFF    = 4'b1111;
  localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;

  logic [DIGIT_W-1:0] bcd_o, bcd_t, bcd_h;
  logic [DIGIT_W-1:0] bcd_o_next, bcd_t_next, bcd_h_next;
  logic               ovf_next;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_wrap;
  logic [SEL_W-1:0]   digit_sel;
  logic [AN_W-1:0]    an_next;
  logic [DIGIT_W-1:0] dig_val;
  logic               dig_blank;
  logic               blank_h, blank_t;

  function automatic logic [SEG_W-1:0] decode(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  // Decimal ripple increment; clear wins over a same-cycle increment.
  always_comb begin
    bcd_o_next = bcd_o;
    bcd_t_next = bcd_t;
    bcd_h_next = bcd_h;
    ovf_next   = ovf;
    if (clear) begin
      bcd_o_next = '0;
      bcd_t_next = '0;
      bcd_h_next = '0;
      ovf_next   = 1'b0;
    end else if (step_valid && z) begin
      if (bcd_o != BCD_MAX) begin
        bcd_o_next = bcd_o + 4'd1;
      end else begin
        bcd_o_next = '0;
        if (bcd_t != BCD_MAX) begin
          bcd_t_next = bcd_t + 4'd1;
        end else begin
          bcd_t_next = '0;
          if (bcd_h != BCD_MAX) begin
            bcd_h_next = bcd_h + 4'd1;
          end else begin
            bcd_h_next = '0;
            ovf_next   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_o <= '0;
      bcd_t <= '0;
      bcd_h <= '0;
      ovf   <= 1'b0;
    end else begin
      bcd_o <= bcd_o_next;
      bcd_t <= bcd_t_next;
      bcd_h <= bcd_h_next;
      ovf   <= ovf_next;
    end
  end

  assign div_wrap = (div_cnt == DIV_W'(REFRESH_DIV - 1));

  // Refresh divider; digit_sel advances once per full dwell period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_sel <= '0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

`ifdef SEQ_DISP_LZB_EN
  assign blank_h = (bcd_h == '0);
  assign blank_t = blank_h && (bcd_t == '0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an_next   = AN_OFF;
    dig_val   = '0;
    dig_blank = 1'b0;
    case (digit_sel)
      2'd0: begin
        an_next = 4'b1110;
        dig_val = {1'b0, state};
      end
      2'd1: begin
        an_next = 4'b1101;
        dig_val = bcd_o;
      end
      2'd2: begin
        an_next   = 4'b1011;
        dig_val   = bcd_t;
        dig_blank = blank_t;
      end
      default: begin
        an_next   = 4'b0111;
        dig_val   = bcd_h;
        dig_blank = blank_h;
      end
    endcase
  end

  // Anode and segments switch together, so no two digits are ever lit at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= AN_OFF;
      seg   <= SEG_BLANK;
    end else begin
      anode <= an_next;
      seg   <= dig_blank ? SEG_BLANK : decode(dig_val);
    end
  end

endmodule

// File: tb/tb_seq_match_display.sv
// Self-checking bench for seq_match_display with a short refresh period;
// display expectations are queued per digit and retired as each digit is scanned.
module tb_seq_match_display;

  localparam int unsigned RD = 4;
  localparam int unsigned DW = 3;
`ifdef SEQ_DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       step_valid;
  logic       z;
  logic [2:0] state;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] anode;
  logic       ovf;

  seq_match_display #(.REFRESH_DIV(RD), .DIV_W(DW)) dut (
    .clk(clk), .reset(reset), .step_valid(step_valid), .z(z), .state(state),
    .clear(clear), .seg(seg), .anode(anode), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sg;
  } disp_t;

  typedef struct {
    bit       sv;
    bit       zz;
    bit       clr;
    bit [2:0] st;
    int       exp_cnt;
    bit       exp_ovf;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] dec_tab [16];
  logic [3:0] an_tab  [4];
  disp_t      sbq [$];
  vec_t       vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit sv, input bit zz, input bit clr);
    @(posedge clk);
    #1;
    step_valid = sv;
    z          = zz;
    clear      = clr;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    z          = 1'b0;
    clear      = 1'b0;
  endtask

  // Queue the four expected digits for count cnt, then retire them as the scan shows each.
  task automatic scan_check(input string name, input int cnt, input bit exp_ovf);
    int    o, t, h, budget;
    disp_t e;
    o = cnt % 10;
    t = (cnt / 10) % 10;
    h = (cnt / 100) % 10;
    e.an = 4'b1110; e.sg = dec_tab[{1'b0, state}]; sbq.push_back(e);
    e.an = 4'b1101; e.sg = dec_tab[o]; sbq.push_back(e);
    e.an = 4'b1011; e.sg = (LZB && h == 0 && t == 0) ? 7'b1111111 : dec_tab[t]; sbq.push_back(e);
    e.an = 4'b0111; e.sg = (LZB && h == 0) ? 7'b1111111 : dec_tab[h]; sbq.push_back(e);
    check($sformatf("%s ovf", name), 32'(ovf), 32'(exp_ovf));
    @(posedge clk);
    budget = 64;
    while (sbq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      check($sformatf("%s one-anode", name), 32'($countones(~anode)), 32'd1);
      if (anode == sbq[0].an) begin
        check($sformatf("%s seg@an=%b", name, anode), 32'(seg), 32'(sbq[0].sg));
        void'(sbq.pop_front());
      end
    end
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scan timeout: %0d digits not seen, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int  zs [17];
    int  run;
    bit  found;

    dec_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // 12 counting and 5 non-counting steps interleaved, then two z=1 without step_valid.
    zs  = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    run = 0;
    for (int i = 0; i < 17; i++) begin
      run += zs[i];
      vecs[i] = '{sv: 1'b1, zz: zs[i][0], clr: 1'b0, st: 3'(i % 8), exp_cnt: run, exp_ovf: 1'b0};
    end
    vecs[17] = '{sv: 1'b0, zz: 1'b1, clr: 1'b0, st: 3'd6, exp_cnt: 12, exp_ovf: 1'b0};
    vecs[18] = '{sv: 1'b0, zz: 1'b1, clr: 1'b0, st: 3'd7, exp_cnt: 12, exp_ovf: 1'b0};

    // Reset and scan order
    reset = 1'b0; step_valid = 1'b0; z = 1'b0; clear = 1'b0; state = 3'd5;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset anode", 32'(anode), 32'h0F);
      check("reset seg", 32'(seg), 32'h7F);
      check("reset ovf", 32'(ovf), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan anode edge %0d", e), 32'(anode), 32'(an_tab[((e - 1) / 4) % 4]));
      if (e == 1) check("first seg state5", 32'(seg), 32'(7'b0100100));
    end

    // Table-driven counting
    for (int i = 0; i < 19; i++) begin
      state = vecs[i].st;
      step(vecs[i].sv, vecs[i].zz, vecs[i].clr);
      scan_check($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_ovf);
    end

    // Carry, wrap and sticky overflow
    state = 3'd2;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 999; i++) step(1'b1, 1'b1, 1'b0);
    scan_check("cnt999", 999, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    scan_check("wrap000", 0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    scan_check("after wrap 001", 1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    scan_check("cnt007", 7, 1'b1);

    // Clear beats a same-cycle increment
    step(1'b1, 1'b1, 1'b1);
    check("clear ovf next clk", 32'(ovf), 32'h0);
    scan_check("clear priority", 0, 1'b0);

    // Async reset mid-scan at count 042
    for (int i = 0; i < 42; i++) step(1'b1, 1'b1, 1'b0);
    scan_check("cnt042", 42, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (anode == 4'b1011) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait digit2: anode=%b never reached, required 1011", anode);
    end
    #2 reset = 1'b0;
    #1;
    check("async reset anode", 32'(anode), 32'h0F);
    check("async reset seg", 32'(seg), 32'h7F);
    check("async reset ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post reset anode", 32'(anode), 32'(4'b1110));
    scan_check("post reset count", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
